// File: rtl/visor_mailbox_if.sv
// Visor-side channel for visor_mailbox: the peek drain stream and the poke request path.
// master = mailbox side, slave = visor side.
interface visor_mailbox_if #(
  parameter int WIDTH = 16,
  parameter int CW    = 1
);
  logic             vs_valid;
  logic             vs_ready;
  logic [WIDTH-1:0] vs_data;
  logic [CW-1:0]    vs_chan;
  logic             vs_poke_valid;
  logic             vs_poke_ready;
  logic [CW-1:0]    vs_poke_chan;
  logic [WIDTH-1:0] vs_poke_data;

  modport master (
    output vs_valid, vs_data, vs_chan, vs_poke_ready,
    input  vs_ready, vs_poke_valid, vs_poke_chan, vs_poke_data
  );

  modport slave (
    input  vs_valid, vs_data, vs_chan, vs_poke_ready,
    output vs_ready, vs_poke_valid, vs_poke_chan, vs_poke_data
  );
endinterface

// File: rtl/visor_mailbox.sv
// Multi-channel peek/poke mailbox between target register strobes and the debug visor.
// Optional VISOR_MAILBOX_OVF_COUNT_EN adds per-channel saturating drop counters (vs_ovf_count).
module visor_mailbox_chan #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  input  logic             ovf_clear,
  input  logic             poke_we,
  input  logic [WIDTH-1:0] poke_din,
  input  logic             tg_read,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic [WIDTH-1:0] poke_data,
  output logic             poke_full
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
  , output logic [7:0]     ovf_count
`endif
);
  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW-1:0]               wp, rp;
  logic [AW:0]                 cnt;
  logic                        push_ok, drop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(DEPTH));
  // a pop on the same edge frees the slot the push needs
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;
  assign head    = mem[rp];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (push_ok) wp <= wp + 1'b1;
      if (pop)     rp <= rp + 1'b1;
      case ({push_ok, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf       <= 1'b0;
      poke_data <= '0;
      poke_full <= 1'b0;
    end else begin
      if (drop)           ovf <= 1'b1;
      else if (ovf_clear) ovf <= 1'b0;
      if (poke_we) begin
        poke_data <= poke_din;
        poke_full <= 1'b1;
      end else if (tg_read) begin
        poke_full <= 1'b0;
      end
    end
  end

`ifdef VISOR_MAILBOX_OVF_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   ovf_count <= '0;
    else if (drop && ovf_clear)   ovf_count <= 8'd1;
    else if (drop)                ovf_count <= (ovf_count == 8'hFF) ? ovf_count : ovf_count + 1'b1;
    else if (ovf_clear)           ovf_count <= '0;
  end
`endif
endmodule

module visor_mailbox #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 4,
  localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      sysclk,
  input  logic                      sysreset,
  input  logic [CHANNELS-1:0]       tg_load,
  input  logic [WIDTH-1:0]          tg_load_data,
  input  logic [CHANNELS-1:0]       tg_read,
  output logic [CHANNELS*WIDTH-1:0] tg_poke_data,
  output logic [CHANNELS-1:0]       tg_poke_full,
  output logic [CHANNELS-1:0]       tg_peek_full,
  output logic [CHANNELS-1:0]       vs_ovf,
  input  logic [CHANNELS-1:0]       vs_ovf_clear,
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
  output logic [CHANNELS*8-1:0]     vs_ovf_count,
`endif
  visor_mailbox_if.master           vs
);
  typedef enum logic {IDLE, OFFER} state_t;

  typedef struct packed {
    logic             valid;
    logic [CW-1:0]    chan;
    logic [WIDTH-1:0] data;
  } peek_rsp_t;

  state_t                      state, state_nxt;
  logic [CW-1:0]               rr, rr_nxt, grant, grant_nxt, pick;
  logic                        found, accept, poke_ready;
  logic [CHANNELS-1:0]         empty, pop, poke_we;
  logic [CHANNELS-1:0][WIDTH-1:0] head, poke_q;
  peek_rsp_t                   rsp;
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
  logic [CHANNELS-1:0][7:0]    ovf_cnt;
  assign vs_ovf_count = ovf_cnt;
`endif

  visor_mailbox_chan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_chan [CHANNELS-1:0] (
    .clk       (sysclk),
    .rst_n     (sysreset),
    .push      (tg_load),
    .din       (tg_load_data),
    .pop       (pop),
    .ovf_clear (vs_ovf_clear),
    .poke_we   (poke_we),
    .poke_din  (vs.vs_poke_data),
    .tg_read   (tg_read),
    .head      (head),
    .empty     (empty),
    .full      (tg_peek_full),
    .ovf       (vs_ovf),
    .poke_data (poke_q),
    .poke_full (tg_poke_full)
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
    , .ovf_count (ovf_cnt)
`endif
  );

  assign tg_poke_data = poke_q;

  // first non-empty channel at rotating distance i from rr
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (!found && !empty[c] && ((int'(rr) + i == c) || (int'(rr) + i == c + CHANNELS))) begin
          found = 1'b1;
          pick  = CW'(c);
        end
      end
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state <= IDLE;
      rr    <= '0;
      grant <= '0;
    end else begin
      state <= state_nxt;
      rr    <= rr_nxt;
      grant <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rr_nxt    = rr;
    grant_nxt = grant;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          grant_nxt = pick;
          state_nxt = OFFER;
        end
      end
      OFFER: begin
        if (vs.vs_ready) begin
          accept    = 1'b1;
          rr_nxt    = (int'(grant) == CHANNELS - 1) ? '0 : grant + 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop = '0;
    for (int c = 0; c < CHANNELS; c++) pop[c] = accept && (grant == CW'(c));
  end

  always_comb begin
    rsp = '0;
    if (state == OFFER) begin
      rsp.valid = 1'b1;
      rsp.chan  = grant;
      for (int c = 0; c < CHANNELS; c++)
        if (grant == CW'(c)) rsp.data = head[c];
    end
  end

  assign vs.vs_valid = rsp.valid;
  assign vs.vs_chan  = rsp.chan;
  assign vs.vs_data  = rsp.data;

  // out-of-range poke channels match no c, so ready stays low
  always_comb begin
    poke_ready = 1'b0;
    for (int c = 0; c < CHANNELS; c++)
      if (vs.vs_poke_chan == CW'(c)) poke_ready = !tg_poke_full[c];
  end

  assign vs.vs_poke_ready = poke_ready;

  always_comb begin
    poke_we = '0;
    for (int c = 0; c < CHANNELS; c++)
      poke_we[c] = vs.vs_poke_valid && poke_ready && (vs.vs_poke_chan == CW'(c));
  end
endmodule

// File: tb/tb_visor_mailbox.sv
// Directed self-checking bench for visor_mailbox (WIDTH=16, CHANNELS=2, DEPTH=4).
// Inputs are driven and outputs sampled 1ns after the rising edge.
module tb_visor_mailbox;
  localparam int WIDTH = 16, CHANNELS = 2, DEPTH = 4, CW = 1;

  logic                      sysclk = 1'b0;
  logic                      sysreset = 1'b0;
  logic [CHANNELS-1:0]       tg_load = '0;
  logic [WIDTH-1:0]          tg_load_data = '0;
  logic [CHANNELS-1:0]       tg_read = '0;
  logic [CHANNELS*WIDTH-1:0] tg_poke_data;
  logic [CHANNELS-1:0]       tg_poke_full, tg_peek_full, vs_ovf;
  logic [CHANNELS-1:0]       vs_ovf_clear = '0;
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
  logic [CHANNELS*8-1:0]     vs_ovf_count;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 sysclk = ~sysclk;

  visor_mailbox_if #(.WIDTH(WIDTH), .CW(CW)) vif ();

  visor_mailbox #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
    .sysclk       (sysclk),
    .sysreset     (sysreset),
    .tg_load      (tg_load),
    .tg_load_data (tg_load_data),
    .tg_read      (tg_read),
    .tg_poke_data (tg_poke_data),
    .tg_poke_full (tg_poke_full),
    .tg_peek_full (tg_peek_full),
    .vs_ovf       (vs_ovf),
    .vs_ovf_clear (vs_ovf_clear),
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
    .vs_ovf_count (vs_ovf_count),
`endif
    .vs           (vif.master)
  );

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic test_reset();
    vif.vs_ready = 1'b0; vif.vs_poke_valid = 1'b0;
    vif.vs_poke_chan = '0; vif.vs_poke_data = '0;
    repeat (2) @(posedge sysclk);
    #2 sysreset = 1'b1;
    tick();
    n_tests++;
    if ({vif.vs_valid, vif.vs_chan, vif.vs_data} !== 18'h0) begin
      n_fail++; $display("FAIL reset_stream: got %h exp 0", {vif.vs_valid, vif.vs_chan, vif.vs_data});
    end
    n_tests++;
    if ({tg_poke_data, tg_poke_full, tg_peek_full, vs_ovf} !== 38'h0) begin
      n_fail++; $display("FAIL reset_flags: got %h exp 0", {tg_poke_data, tg_poke_full, tg_peek_full, vs_ovf});
    end
    n_tests++;
    if (vif.vs_poke_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_poke_ready: got %b exp 1", vif.vs_poke_ready);
    end
  endtask

  task automatic test_latency();
    tg_load_data = 16'h1234; tg_load = 2'b01;
    tick();
    tg_load = '0;
    n_tests++;
    if (vif.vs_valid !== 1'b0) begin
      n_fail++; $display("FAIL lat_edge_k: got valid %b exp 0", vif.vs_valid);
    end
    tick();
    n_tests++;
    if ({vif.vs_valid, vif.vs_chan, vif.vs_data} !== {1'b1, 1'b0, 16'h1234}) begin
      n_fail++; $display("FAIL lat_offer: got %h exp %h", {vif.vs_valid, vif.vs_chan, vif.vs_data}, {1'b1, 1'b0, 16'h1234});
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_tests++;
      if ({vif.vs_valid, vif.vs_chan, vif.vs_data} !== {1'b1, 1'b0, 16'h1234}) begin
        n_fail++; $display("FAIL lat_hold%0d: got %h exp %h", i, {vif.vs_valid, vif.vs_chan, vif.vs_data}, {1'b1, 1'b0, 16'h1234});
      end
    end
    vif.vs_ready = 1'b1;
    tick();
    vif.vs_ready = 1'b0;
    n_tests++;
    if ({vif.vs_valid, vif.vs_data} !== 17'h0) begin
      n_fail++; $display("FAIL lat_accept: got %h exp 0", {vif.vs_valid, vif.vs_data});
    end
  endtask

  task automatic test_round_robin();
    logic [15:0] ld_data [6] = '{16'hA000, 16'hA001, 16'hA002, 16'hB000, 16'hB001, 16'hB002};
    logic [15:0] exp_data [6] = '{16'hA000, 16'hB000, 16'hA001, 16'hB001, 16'hA002, 16'hB002};
    int got = 0;
    for (int i = 0; i < 6; i++) begin
      tg_load = (i < 3) ? 2'b01 : 2'b10;
      tg_load_data = ld_data[i];
      tick();
    end
    tg_load = '0;
    vif.vs_ready = 1'b1;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      if (vif.vs_valid === 1'b1) begin
        n_tests++;
        if ({vif.vs_chan, vif.vs_data} !== {got[0], exp_data[got]}) begin
          n_fail++; $display("FAIL rr_word%0d: got %h exp %h", got, {vif.vs_chan, vif.vs_data}, {got[0], exp_data[got]});
        end
        got++;
      end
      tick();
    end
    vif.vs_ready = 1'b0;
    n_tests++;
    if (got != 6) begin
      n_fail++; $display("FAIL rr_count: got %0d words exp 6", got);
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 5; i++) begin
      tg_load = 2'b10; tg_load_data = 16'hC000 + 16'(i);
      tick();
      if (i == 3) begin
        n_tests++;
        if ({tg_peek_full, vs_ovf} !== 4'b10_00) begin
          n_fail++; $display("FAIL ovf_full4: got full/ovf %b exp 1000", {tg_peek_full, vs_ovf});
        end
      end
    end
    tg_load = '0;
    n_tests++;
    if ({tg_peek_full, vs_ovf} !== 4'b10_10) begin
      n_fail++; $display("FAIL ovf_set: got full/ovf %b exp 1010", {tg_peek_full, vs_ovf});
    end
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
    n_tests++;
    if (vs_ovf_count !== 16'h0100) begin
      n_fail++; $display("FAIL ovf_count: got %h exp 0100", vs_ovf_count);
    end
`endif
    vs_ovf_clear = 2'b10;
    tick();
    vs_ovf_clear = '0;
    n_tests++;
    if (vs_ovf !== 2'b00) begin
      n_fail++; $display("FAIL ovf_clear: got %b exp 00", vs_ovf);
    end
`ifdef VISOR_MAILBOX_OVF_COUNT_EN
    n_tests++;
    if (vs_ovf_count !== 16'h0000) begin
      n_fail++; $display("FAIL ovf_count_clear: got %h exp 0000", vs_ovf_count);
    end
`endif
  endtask

  task automatic test_push_pop_full();
    logic [15:0] exp_data [4] = '{16'hC001, 16'hC002, 16'hC003, 16'hC005};
    int got = 0;
    n_tests++;
    if ({vif.vs_valid, vif.vs_chan, vif.vs_data} !== {1'b1, 1'b1, 16'hC000}) begin
      n_fail++; $display("FAIL ppf_offer: got %h exp %h", {vif.vs_valid, vif.vs_chan, vif.vs_data}, {1'b1, 1'b1, 16'hC000});
    end
    tg_load = 2'b10; tg_load_data = 16'hC005; vif.vs_ready = 1'b1;
    tick();
    tg_load = '0; vif.vs_ready = 1'b0;
    n_tests++;
    if ({vif.vs_valid, tg_peek_full, vs_ovf} !== 5'b0_10_00) begin
      n_fail++; $display("FAIL ppf_state: got valid/full/ovf %b exp 01000", {vif.vs_valid, tg_peek_full, vs_ovf});
    end
    vif.vs_ready = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (vif.vs_valid === 1'b1) begin
        if (got < 4) begin
          n_tests++;
          if ({vif.vs_chan, vif.vs_data} !== {1'b1, exp_data[got]}) begin
            n_fail++; $display("FAIL ppf_word%0d: got %h exp %h", got, {vif.vs_chan, vif.vs_data}, {1'b1, exp_data[got]});
          end
        end
        got++;
      end
      tick();
    end
    vif.vs_ready = 1'b0;
    n_tests++;
    if (got != 4) begin
      n_fail++; $display("FAIL ppf_count: got %0d words exp 4", got);
    end
    n_tests++;
    if ({vif.vs_valid, tg_peek_full} !== 3'b0) begin
      n_fail++; $display("FAIL ppf_drained: got valid/full %b exp 000", {vif.vs_valid, tg_peek_full});
    end
  endtask

  task automatic test_poke();
    vif.vs_poke_chan = 1'b1; vif.vs_poke_data = 16'h00FF; vif.vs_poke_valid = 1'b1;
    #1;
    n_tests++;
    if (vif.vs_poke_ready !== 1'b1) begin
      n_fail++; $display("FAIL poke_ready_pre: got %b exp 1", vif.vs_poke_ready);
    end
    tick();
    vif.vs_poke_valid = 1'b0;
    n_tests++;
    if ({tg_poke_data, tg_poke_full, vif.vs_poke_ready} !== {32'h00FF_0000, 2'b10, 1'b0}) begin
      n_fail++; $display("FAIL poke_load: got %h exp %h", {tg_poke_data, tg_poke_full, vif.vs_poke_ready}, {32'h00FF_0000, 2'b10, 1'b0});
    end
    vif.vs_poke_data = 16'h1111; vif.vs_poke_valid = 1'b1;
    tick();
    vif.vs_poke_valid = 1'b0;
    n_tests++;
    if (tg_poke_data !== 32'h00FF_0000) begin
      n_fail++; $display("FAIL poke_blocked: got %h exp 00ff0000", tg_poke_data);
    end
    vif.vs_poke_chan = 1'b0;
    #1;
    n_tests++;
    if (vif.vs_poke_ready !== 1'b1) begin
      n_fail++; $display("FAIL poke_ready_ch0: got %b exp 1", vif.vs_poke_ready);
    end
    tg_read = 2'b10;
    tick();
    tg_read = '0;
    n_tests++;
    if ({tg_poke_data, tg_poke_full} !== {32'h00FF_0000, 2'b00}) begin
      n_fail++; $display("FAIL poke_read: got %h exp %h", {tg_poke_data, tg_poke_full}, {32'h00FF_0000, 2'b00});
    end
    vif.vs_poke_chan = 1'b1; vif.vs_poke_data = 16'h0100; vif.vs_poke_valid = 1'b1;
    #1;
    n_tests++;
    if (vif.vs_poke_ready !== 1'b1) begin
      n_fail++; $display("FAIL poke_ready_again: got %b exp 1", vif.vs_poke_ready);
    end
    tick();
    vif.vs_poke_valid = 1'b0;
    n_tests++;
    if ({tg_poke_data, tg_poke_full} !== {32'h0100_0000, 2'b10}) begin
      n_fail++; $display("FAIL poke_second: got %h exp %h", {tg_poke_data, tg_poke_full}, {32'h0100_0000, 2'b10});
    end
    tg_read = 2'b01;
    tick();
    tg_read = '0;
    n_tests++;
    if ({tg_poke_data, tg_poke_full} !== {32'h0100_0000, 2'b10}) begin
      n_fail++; $display("FAIL poke_read_empty: got %h exp %h", {tg_poke_data, tg_poke_full}, {32'h0100_0000, 2'b10});
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) begin
      tg_load = 2'b01; tg_load_data = 16'hD000 + 16'(i);
      tick();
    end
    tg_load = '0;
    n_tests++;
    if ({vif.vs_valid, tg_peek_full, vs_ovf, tg_poke_full} !== 7'b1_01_01_10) begin
      n_fail++; $display("FAIL rst_pre: got valid/pfull/ovf/kfull %b exp 1010110", {vif.vs_valid, tg_peek_full, vs_ovf, tg_poke_full});
    end
    #2 sysreset = 1'b0;
    #1;
    n_tests++;
    if ({vif.vs_valid, vif.vs_data, tg_peek_full, vs_ovf, tg_poke_full} !== 23'h0) begin
      n_fail++; $display("FAIL rst_async_flags: got %h exp 0", {vif.vs_valid, vif.vs_data, tg_peek_full, vs_ovf, tg_poke_full});
    end
    n_tests++;
    if ({tg_poke_data, vif.vs_poke_ready} !== {32'h0, 1'b1}) begin
      n_fail++; $display("FAIL rst_async_poke: got %h exp %h", {tg_poke_data, vif.vs_poke_ready}, {32'h0, 1'b1});
    end
    @(posedge sysclk);
    #2 sysreset = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({vif.vs_valid, tg_peek_full} !== 3'b0) begin
      n_fail++; $display("FAIL rst_dropped: got valid/full %b exp 000", {vif.vs_valid, tg_peek_full});
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_round_robin();
    test_overflow();
    test_push_pop_full();
    test_poke();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, exp completion");
    $fatal(1);
  end
endmodule

// File: doc/visor_mailbox.md
# visor_mailbox

Parametrised peek/poke mailbox that replaces the single debug peek register on the Synapse316 target with CHANNELS independent bidirectional channels. Target-to-visor words are buffered in per-channel FIFOs and drained by the debugging supervisor through a round-robin-arbitrated valid/ready stream. Visor-to-target words sit in one-entry poke registers that the target consumes through its register-file read strobes. The block sits between the target's register-file load/read strobes and the visor.

## Interface
- WIDTH, 16: data word width.
- CHANNELS, 2: number of mailbox channels, 1..8.
- DEPTH, 4: peek FIFO entries per channel; power of 2, at least 2.
- CW, derived as max(1, clog2(CHANNELS)): channel index width.

Ports:
- sysclk  in  1  sole clock, rising edge.
- sysreset  in  1  asynchronous, active-low reset.
- tg_load  in  CHANNELS  target register-load strobe per channel; pushes tg_load_data.
- tg_load_data  in  WIDTH  target store data.
- tg_read  in  CHANNELS  target register-read strobe per channel; consumes the poke word.
- tg_poke_data  out  CHANNELS*WIDTH  poke register contents; channel c occupies bits [c*WIDTH +: WIDTH].
- tg_poke_full  out  CHANNELS  poke register holds an unread word.
- tg_peek_full  out  CHANNELS  peek FIFO full.
- vs_valid  out  1  peek word offered to visor.
- vs_ready  in  1  visor accepts the offered word.
- vs_data  out  WIDTH  offered word.
- vs_chan  out  CW  channel of the offered word.
- vs_poke_valid  in  1  visor poke request.
- vs_poke_chan  in  CW  poke target channel.
- vs_poke_data  in  WIDTH  poke word.
- vs_poke_ready  out  1  combinational; equals !tg_poke_full[vs_poke_chan].
- vs_ovf  out  CHANNELS  sticky per-channel overflow flags.
- vs_ovf_clear  in  CHANNELS  single-cycle clear pulse per channel.

## Operation
- Each channel has a peek FIFO with write pointer, read pointer and count 0..DEPTH. Pointers wrap modulo DEPTH.
- Push on tg_load[c]:
  - Accepted if count < DEPTH, or if the same edge pops channel c.
  - A simultaneous push and pop on a full FIFO leaves count at DEPTH.
- Overflow: tg_load[c] on a full FIFO that is not popped on the same edge drops the word and sets vs_ovf[c].
  - vs_ovf_clear[c] clears the flag.
  - If set and clear coincide, set wins.
- The drain arbiter has two states, IDLE and OFFER. The rotating pointer rr resets to 0.
  - IDLE: if any FIFO is non-empty, register grant = the first non-empty channel searching upward from rr, wrapping. Go to OFFER.
  - OFFER: vs_valid=1, vs_chan=grant, vs_data=head of FIFO[grant]. The grant is frozen, so vs_chan and vs_data stay stable until accepted.
  - On vs_ready: pop FIFO[grant], set rr = (grant+1) mod CHANNELS, return to IDLE.
  - While not in OFFER, vs_data and vs_chan are 0.
- Poke:
  - When vs_poke_valid and vs_poke_ready are both 1, the poke register of vs_poke_chan loads vs_poke_data and its full flag is set.
  - tg_read[c] clears tg_poke_full[c]; data is retained.
  - tg_read on an empty poke register has no effect.
- Out-of-range channel indices (vs_poke_chan >= CHANNELS) force vs_poke_ready=0 and are ignored.

## Timing
- Reset values, all outputs: vs_valid 0, vs_data 0, vs_chan 0, tg_poke_data 0, tg_poke_full 0, tg_peek_full 0, vs_ovf 0, vs_poke_ready 1. Also FIFO counts 0, rr 0, state IDLE.
- Assertion of sysreset mid-transfer drops all buffered words immediately. Deassertion is synchronised externally.
- Peek latency: tg_load at edge k gives vs_valid high after edge k+1, provided the arbiter is in IDLE with other FIFOs empty.
- Peek throughput: one word per 2 cycles.
- tg_peek_full updates on the edge following the push or pop.
- Poke: accepted at edge k; tg_poke_full and tg_poke_data valid after edge k. vs_poke_ready reflects the new state combinationally from then on.

## Configuration
- VISOR_MAILBOX_OVF_COUNT_EN defined: adds output vs_ovf_count, CHANNELS*8 bits.
  - One saturating counter per channel; increments on every dropped word and holds at 255.
  - Cleared by vs_ovf_clear[c]; increment wins on coincidence, leaving the count at 1.
- Undefined: the port and counters are absent; only the sticky vs_ovf flags exist.

## Test plan
- Reset, then tg_load[0] with 16'h1234 at edge k -> vs_valid=1, vs_chan=0, vs_data=16'h1234 after edge k+1. Hold vs_ready=0 for 5 cycles: outputs stable. Assert vs_ready: vs_valid=0 next cycle.
- Load channel 0 with 16'hA000..A002 and channel 1 with 16'hB000..B002, vs_ready held 1 -> order A000, B000, A001, B001, A002, B002.
- DEPTH=4, vs_ready=0, five loads on channel 1 -> tg_peek_full[1]=1 after the 4th, vs_ovf[1]=1 after the 5th, and the 5th word is never delivered. vs_ovf_clear[1] -> 0. With VISOR_MAILBOX_OVF_COUNT_EN, count=1 before the clear.
- Full FIFO, with push and pop on the same edge -> both take effect, count stays 4, vs_ovf stays 0.
- Poke channel 1 with 16'h00FF -> tg_poke_full[1]=1, vs_poke_ready=0 for channel 1. tg_read[1] -> full clears; a second poke with 16'h0100 is accepted.
- Assert sysreset while vs_valid=1 -> vs_valid, all flags and tg_poke_data go to 0 immediately, with no clock edge needed.
